// File: rtl/spi_read_module.sv
// SPI receiver: synchronizes CS/A0/SCLK/DI into CLOCK, shifts bytes MSB first on SCLK rises.
// Optional macro SPI_RX_FRAME_ERR_EN enables the Frame_Err pulse on aborted partial bytes.
module spi_read_module #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic [3:0] SPI_In,
  output logic [7:0] Rx_Data,
  output logic       Rx_A0,
  output logic       Done_Sig,
  output logic       Busy,
  output logic       Frame_Err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, a0_sync_q, sclk_sync_q, di_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_d, a0_sync_d, sclk_sync_d, di_sync_d;
  logic       sclk_hist_q, sclk_hist_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_a0_q, rx_a0_d;
  logic       done_q, done_d;
  logic       cs_s, a0_s, sclk_s, di_s, rise, abort;

  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   SPI_In[3]};
  assign a0_sync_d   = {a0_sync_q[SYNC_STAGES-2:0],   SPI_In[2]};
  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_In[1]};
  assign di_sync_d   = {di_sync_q[SYNC_STAGES-2:0],   SPI_In[0]};
  assign sclk_hist_d = sclk_s;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign a0_s   = a0_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign di_s   = di_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_hist_q;

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q     <= IDLE;
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      a0_sync_q   <= '0;
      di_sync_q   <= '0;
      sclk_hist_q <= 1'b1;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      rx_data_q   <= 8'h00;
      rx_a0_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      a0_sync_q   <= a0_sync_d;
      di_sync_q   <= di_sync_d;
      sclk_hist_q <= sclk_hist_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_a0_q     <= rx_a0_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = SHIFT;
      SHIFT:   if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A rise that lands together with CS release still completes a pending 8th bit.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rx_data_d = rx_data_q;
    rx_a0_d   = rx_a0_q;
    done_d    = 1'b0;
    abort     = 1'b0;
    if (state_q == SHIFT) begin
      if (rise && (!cs_s || cnt_q == 3'd7)) begin
        shift_d = {shift_q[6:0], di_s};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rx_data_d = {shift_q[6:0], di_s};
          rx_a0_d   = a0_s;
          done_d    = 1'b1;
        end
      end else if (cs_s) begin
        abort   = (cnt_q != 3'd0);
        cnt_d   = 3'd0;
        shift_d = 8'h00;
      end
    end
  end

  assign Rx_Data  = rx_data_q;
  assign Rx_A0    = rx_a0_q;
  assign Done_Sig = done_q;
  assign Busy     = (state_q == SHIFT);

`ifdef SPI_RX_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge CLOCK) begin
    if (RST) frame_err_q <= 1'b0;
    else     frame_err_q <= abort;
  end
  assign Frame_Err = frame_err_q;
`else
  assign Frame_Err = 1'b0;
`endif

endmodule
